// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Optional SERIAL_SUB_SAT_EN clamps diff to 0 when the final borrow is set.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             bit_d;
  logic             br_next;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell on the current LSBs plus the registered borrow.
  always_comb begin
    bit_d     = a_q[0] ^ b_q[0] ^ br_q;
    br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_shift = {bit_d, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        // Last bit-step: publish the fully shifted result on this same edge.
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
          bout_d  = br_next;
`ifdef SERIAL_SUB_SAT_EN
          diff_d  = br_next ? '0 : res_shift;
`else
          diff_d  = res_shift;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Expected values are hand-computed; SERIAL_SUB_SAT_EN selects the clamped ones.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int checks;
  int passes;

`ifdef SERIAL_SUB_SAT_EN
  localparam logic [WIDTH-1:0] EXP_5_10  = 8'd0;
  localparam logic [WIDTH-1:0] EXP_0_1   = 8'd0;
  localparam logic [WIDTH-1:0] EXP_1_100 = 8'd0;
`else
  localparam logic [WIDTH-1:0] EXP_5_10  = 8'd251;
  localparam logic [WIDTH-1:0] EXP_0_1   = 8'd255;
  localparam logic [WIDTH-1:0] EXP_1_100 = 8'd157;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from a non-busy state and wait (bounded) for done.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        output int lat, output int busy_cycles);
    int n;
    start = 1'b1;
    a = av;
    b = bv;
    tick();
    start = 1'b0;
    a = '0;
    b = '0;
    n = 0;
    busy_cycles = 0;
    lat = -1;
    while (n < 40) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cycles++;
      tick();
      n++;
    end
    if (lat < 0) $display("[TB] FAIL run_op timeout: no done within 40 cycles");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0b expected 0", done); else passes++;
    checks++; if (diff !== 8'd0) $display("[TB] FAIL reset_diff: got %0d expected 0", diff); else passes++;
    checks++; if (bout !== 1'b0) $display("[TB] FAIL reset_bout: got %0b expected 0", bout); else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(8'd200, 8'd55, lat, bc);
    checks++; if (lat != 8) $display("[TB] FAIL basic_latency: got %0d expected 8", lat); else passes++;
    checks++; if (bc != 8) $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bc); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_at_done: got %0b expected 0", busy); else passes++;
    checks++; if (diff !== 8'd145) $display("[TB] FAIL basic_diff: got %0d expected 145", diff); else passes++;
    checks++; if (bout !== 1'b0) $display("[TB] FAIL basic_bout: got %0b expected 0", bout); else passes++;
    tick();
    checks++; if (done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %0b expected 0", done); else passes++;
    checks++; if (diff !== 8'd145) $display("[TB] FAIL basic_diff_hold: got %0d expected 145", diff); else passes++;
  endtask

  task automatic test_borrow();
    int lat, bc;
    run_op(8'd5, 8'd10, lat, bc);
    checks++; if (lat != 8) $display("[TB] FAIL borrow_latency: got %0d expected 8", lat); else passes++;
    checks++; if (diff !== EXP_5_10) $display("[TB] FAIL borrow_diff: got %0d expected %0d", diff, EXP_5_10); else passes++;
    checks++; if (bout !== 1'b1) $display("[TB] FAIL borrow_bout: got %0b expected 1", bout); else passes++;
    tick();
  endtask

  task automatic test_boundaries();
    int lat, bc;
    run_op(8'd0, 8'd0, lat, bc);
    checks++; if (diff !== 8'd0 || bout !== 1'b0) $display("[TB] FAIL zero_zero: got %0d/%0b expected 0/0", diff, bout); else passes++;
    tick();
    run_op(8'd0, 8'd1, lat, bc);
    checks++; if (diff !== EXP_0_1 || bout !== 1'b1) $display("[TB] FAIL zero_one: got %0d/%0b expected %0d/1", diff, bout, EXP_0_1); else passes++;
    tick();
    run_op(8'd255, 8'd255, lat, bc);
    checks++; if (diff !== 8'd0 || bout !== 1'b0) $display("[TB] FAIL max_max: got %0d/%0b expected 0/0", diff, bout); else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    int ndone;
    int t0, t1;
    logic [WIDTH-1:0] d0, d1;
    logic bo0, bo1;
    ndone = 0;
    t0 = -1; t1 = -1;
    d0 = '0; d1 = '0; bo0 = 1'b0; bo1 = 1'b0;
    start = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc == 0) begin
        a = 8'd100; b = 8'd1;
      end else if (cyc == 9) begin
        a = 8'd1; b = 8'd100;
      end else begin
        a = 8'(cyc * 37 + 3);
        b = 8'(cyc * 11 + 90);
      end
      tick();
      if (done) begin
        if (ndone == 0) begin
          t0 = cyc; d0 = diff; bo0 = bout;
        end else if (ndone == 1) begin
          t1 = cyc; d1 = diff; bo1 = bout;
        end
        ndone++;
      end
    end
    start = 1'b0;
    tick();
    checks++; if (ndone != 2) $display("[TB] FAIL b2b_done_count: got %0d expected 2", ndone); else passes++;
    checks++; if (t0 != 8) $display("[TB] FAIL b2b_first_done_cycle: got %0d expected 8", t0); else passes++;
    checks++; if (t1 - t0 != 9) $display("[TB] FAIL b2b_done_spacing: got %0d expected 9", t1 - t0); else passes++;
    checks++; if (d0 !== 8'd99 || bo0 !== 1'b0) $display("[TB] FAIL b2b_first_result: got %0d/%0b expected 99/0", d0, bo0); else passes++;
    checks++; if (d1 !== EXP_1_100 || bo1 !== 1'b1) $display("[TB] FAIL b2b_second_result: got %0d/%0b expected %0d/1", d1, bo1, EXP_1_100); else passes++;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL b2b_idle_after: got busy=%0b done=%0b expected 0/0", busy, done); else passes++;
  endtask

  task automatic test_ignore_start();
    int ndone;
    int tdone;
    ndone = 0;
    tdone = -1;
    start = 1'b1;
    a = 8'd50;
    b = 8'd20;
    tick();
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) begin
        start = 1'b1; a = 8'd9; b = 8'd200;
      end else begin
        start = 1'b0; a = '0; b = '0;
      end
      tick();
      if (done) begin
        ndone++;
        tdone = n;
      end
    end
    checks++; if (ndone != 1) $display("[TB] FAIL ignore_done_count: got %0d expected 1", ndone); else passes++;
    checks++; if (tdone != 8) $display("[TB] FAIL ignore_done_cycle: got %0d expected 8", tdone); else passes++;
    checks++; if (diff !== 8'd30 || bout !== 1'b0) $display("[TB] FAIL ignore_result: got %0d/%0b expected 30/0", diff, bout); else passes++;
  endtask

  task automatic test_reset_mid();
    int ndone, lat, bc;
    ndone = 0;
    start = 1'b1;
    a = 8'd77;
    b = 8'd33;
    tick();
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %0b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL midreset_done: got %0b expected 0", done); else passes++;
    checks++; if (diff !== 8'd0) $display("[TB] FAIL midreset_diff: got %0d expected 0", diff); else passes++;
    checks++; if (bout !== 1'b0) $display("[TB] FAIL midreset_bout: got %0b expected 0", bout); else passes++;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (done) ndone++;
    end
    checks++; if (ndone != 0) $display("[TB] FAIL midreset_no_done: got %0d expected 0", ndone); else passes++;
    run_op(8'd77, 8'd33, lat, bc);
    checks++; if (lat != 8) $display("[TB] FAIL midreset_latency: got %0d expected 8", lat); else passes++;
    checks++; if (diff !== 8'd44 || bout !== 1'b0) $display("[TB] FAIL midreset_result: got %0d/%0b expected 44/0", diff, bout); else passes++;
    tick();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    test_reset();
    test_basic();
    test_borrow();
    test_boundaries();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
